// File: rtl/vit_stream_pkg.sv
// Shared types and width defaults for the soft-symbol / decoded-bit stream adapter.
package vit_stream_pkg;

  localparam int SOFT_W_DEF  = 8;
  localparam int DEPTH_DEF   = 16;
  localparam int OUT_W_DEF   = 16;
  localparam int STATE_W_DEF = 6;

  typedef enum logic {
    PACK = 1'b0,
    HOLD = 1'b1
  } pack_state_e;

endpackage

// File: rtl/vit_sym_fifo.sv
// Soft-symbol FIFO: power-of-two depth, explicit occupancy count, registered read data.
module vit_sym_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wr_data,
  output logic [W-1:0]               rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [W-1:0]  rd_data_reg;
  logic          do_push, do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a write when a slot is freed in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      rd_data_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop) begin
        rd_ptr_reg  <= rd_ptr_reg + 1'b1;
        rd_data_reg <= mem[rd_ptr_reg];
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rd_data = rd_data_reg;
  assign count   = count_reg;

endmodule

// File: rtl/vit_stream_adapter.sv
// Host-to-decoder symbol feeder plus decoded-bit word packer.
// Statistics (sym_count, in_ovf, out_ovf) exist only with VIT_STREAM_ADAPTER_STATS_EN defined.
module vit_stream_adapter
  import vit_stream_pkg::*;
#(
  parameter int SOFT_W    = SOFT_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int OUT_W     = OUT_W_DEF,
  parameter int STATE_W   = STATE_W_DEF,
  parameter int EDGE_MODE = 1
) (
  input  logic                       clk,
  input  logic                       sys_rst,
  input  logic                       host_valid,
  input  logic signed [SOFT_W-1:0]   host_soft,
  input  logic                       flush,
  input  logic                       dec_ready_in,
  output logic signed [SOFT_W-1:0]   dec_soft,
  output logic                       dec_valid_in,
  input  logic                       dec_valid_out,
  input  logic                       dec_bit,
  input  logic [STATE_W-1:0]         dec_last_state,
  output logic                       out_valid,
  output logic [OUT_W-1:0]           out_word,
  output logic [$clog2(OUT_W+1)-1:0] out_count,
  output logic [STATE_W-1:0]         out_state,
  input  logic                       out_ack,
  output logic                       in_ovf,
  output logic                       out_ovf,
  output logic [31:0]                sym_count,
  output logic [$clog2(DEPTH+1)-1:0] fill
);

  localparam int IDXW = $clog2(OUT_W);
  localparam int CNTW = $clog2(OUT_W+1);

  logic host_valid_prev_reg;
  logic push, pop;
  logic fifo_full, fifo_empty;
  logic dec_valid_in_reg;

  assign push = (EDGE_MODE != 0) ? (host_valid && !host_valid_prev_reg) : host_valid;
  // Blocking the pop while a strobe is out guarantees an idle cycle between strobes.
  assign pop  = !fifo_empty && dec_ready_in && !dec_valid_in_reg;

  vit_sym_fifo #(.W(SOFT_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .srst    (sys_rst),
    .push    (push),
    .pop     (pop),
    .wr_data (host_soft),
    .rd_data (dec_soft),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fill)
  );

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      host_valid_prev_reg <= 1'b0;
      dec_valid_in_reg    <= 1'b0;
    end else begin
      host_valid_prev_reg <= host_valid;
      dec_valid_in_reg    <= pop;
    end
  end

  assign dec_valid_in = dec_valid_in_reg;

  pack_state_e       state_reg;
  logic [IDXW-1:0]   idx_reg;
  logic [OUT_W-1:0]  out_word_reg;
  logic [CNTW-1:0]   out_count_reg;
  logic [STATE_W-1:0] out_state_reg;
  logic              out_valid_reg;
  logic [OUT_W-1:0]  bit_sel;

  for (genvar gi = 0; gi < OUT_W; gi++) begin : g_bit_sel
    assign bit_sel[gi] = (idx_reg == IDXW'(gi));
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_reg     <= PACK;
      idx_reg       <= '0;
      out_word_reg  <= '0;
      out_count_reg <= '0;
      out_state_reg <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        PACK: begin
          if (dec_valid_out) begin
            out_word_reg  <= out_word_reg | (bit_sel & {OUT_W{dec_bit}});
            out_state_reg <= dec_last_state;
          end
          if (dec_valid_out && idx_reg == IDXW'(OUT_W-1)) begin
            out_count_reg <= CNTW'(OUT_W);
            idx_reg       <= '0;
            out_valid_reg <= 1'b1;
            state_reg     <= HOLD;
          end else if (flush && (dec_valid_out || idx_reg != '0)) begin
            // A bit arriving with the flush belongs to the flushed word.
            out_count_reg <= CNTW'(idx_reg) + CNTW'(dec_valid_out);
            idx_reg       <= '0;
            out_valid_reg <= 1'b1;
            state_reg     <= HOLD;
          end else if (dec_valid_out) begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        HOLD: begin
          if (out_ack) begin
            out_word_reg  <= '0;
            out_count_reg <= '0;
            out_valid_reg <= 1'b0;
            state_reg     <= PACK;
          end
        end
        default: state_reg <= PACK;
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign out_word  = out_word_reg;
  assign out_count = out_count_reg;
  assign out_state = out_state_reg;

`ifdef VIT_STREAM_ADAPTER_STATS_EN
  logic [31:0] sym_count_reg;
  logic        in_ovf_reg, out_ovf_reg;
  logic        in_drop, bit_drop;

  assign in_drop  = push && fifo_full && !pop;
  assign bit_drop = (state_reg == HOLD) && dec_valid_out;

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      sym_count_reg <= '0;
      in_ovf_reg    <= 1'b0;
      out_ovf_reg   <= 1'b0;
    end else begin
      if (pop)      sym_count_reg <= sym_count_reg + 32'd1;
      if (in_drop)  in_ovf_reg    <= 1'b1;
      if (bit_drop) out_ovf_reg   <= 1'b1;
    end
  end

  assign sym_count = sym_count_reg;
  assign in_ovf    = in_ovf_reg;
  assign out_ovf   = out_ovf_reg;
`else
  assign sym_count = '0;
  assign in_ovf    = 1'b0;
  assign out_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_vit_stream_adapter.sv
// Self-checking bench for vit_stream_adapter (default parameters, EDGE_MODE=1).
module tb_vit_stream_adapter;

  localparam int SOFT_W  = 8;
  localparam int DEPTH   = 16;
  localparam int OUT_W   = 16;
  localparam int STATE_W = 6;
`ifdef VIT_STREAM_ADAPTER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk;
  logic              sys_rst;
  logic              host_valid;
  logic [SOFT_W-1:0] host_soft;
  logic              flush;
  logic              dec_ready_in;
  logic [SOFT_W-1:0] dec_soft;
  logic              dec_valid_in;
  logic              dec_valid_out;
  logic              dec_bit;
  logic [STATE_W-1:0] dec_last_state;
  logic              out_valid;
  logic [OUT_W-1:0]  out_word;
  logic [4:0]        out_count;
  logic [STATE_W-1:0] out_state;
  logic              out_ack;
  logic              in_ovf;
  logic              out_ovf;
  logic [31:0]       sym_count;
  logic [4:0]        fill;

  int tests_run = 0;
  int tests_failed = 0;

  vit_stream_adapter #(
    .SOFT_W(SOFT_W), .DEPTH(DEPTH), .OUT_W(OUT_W), .STATE_W(STATE_W), .EDGE_MODE(1)
  ) dut (
    .clk(clk), .sys_rst(sys_rst), .host_valid(host_valid), .host_soft(host_soft),
    .flush(flush), .dec_ready_in(dec_ready_in), .dec_soft(dec_soft),
    .dec_valid_in(dec_valid_in), .dec_valid_out(dec_valid_out), .dec_bit(dec_bit),
    .dec_last_state(dec_last_state), .out_valid(out_valid), .out_word(out_word),
    .out_count(out_count), .out_state(out_state), .out_ack(out_ack),
    .in_ovf(in_ovf), .out_ovf(out_ovf), .sym_count(sym_count), .fill(fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1; host_valid = 1'b0; host_soft = '0; flush = 1'b0;
    dec_ready_in = 1'b0; dec_valid_out = 1'b0; dec_bit = 1'b0;
    dec_last_state = '0; out_ack = 1'b0;
    tick(); tick();
    sys_rst = 1'b0;
    tick();
  endtask

  // One rising edge of host_valid carrying value v.
  task automatic push_sym(input logic [SOFT_W-1:0] v);
    host_soft = v; host_valid = 1'b1; tick();
    host_valid = 1'b0; tick();
  endtask

  task automatic send_bit(input logic b, input logic [STATE_W-1:0] st);
    dec_valid_out = 1'b1; dec_bit = b; dec_last_state = st; tick();
    dec_valid_out = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({dec_valid_in, dec_soft, out_valid, out_word, out_count, out_state,
         in_ovf, out_ovf, sym_count, fill} !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: outputs not zero (dvi=%b soft=%h ov=%b word=%h cnt=%0d fill=%0d)",
               dec_valid_in, dec_soft, out_valid, out_word, out_count, fill);
    end
  endtask

  task automatic test_edge_level();
    int pulses = 0;
    logic [SOFT_W-1:0] got = '0;
    do_reset();
    dec_ready_in = 1'b1; host_soft = 8'hFB; host_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (dec_valid_in) begin pulses++; got = dec_soft; end
    end
    host_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (dec_valid_in) pulses++;
    end
    tests_run++;
    if (pulses != 1) begin tests_failed++; $display("FAIL edge_pulses: got %0d want 1", pulses); end
    tests_run++;
    if (got !== 8'hFB) begin tests_failed++; $display("FAIL edge_soft: got %h want fb", got); end
    tests_run++;
    if (sym_count !== (STATS ? 32'd1 : 32'd0)) begin
      tests_failed++; $display("FAIL edge_sym_count: got %0d want %0d", sym_count, STATS ? 1 : 0);
    end
    $display("[TB] edge_level: pulses=%0d soft=%h sym_count=%0d", pulses, got, sym_count);
  endtask

  task automatic test_fifo_overflow();
    int idx = 0;
    int gap_err = 0;
    logic prev = 1'b0;
    do_reset();
    for (int i = 0; i < 20; i++) push_sym(SOFT_W'(i));
    tests_run++;
    if (fill !== 5'd16) begin tests_failed++; $display("FAIL ovf_fill: got %0d want 16", fill); end
    tests_run++;
    if (in_ovf !== STATS) begin tests_failed++; $display("FAIL ovf_flag: got %b want %b", in_ovf, STATS); end
    dec_ready_in = 1'b1;
    for (int c = 0; c < 200 && idx < 16; c++) begin
      tick();
      if (dec_valid_in) begin
        if (prev) gap_err++;
        tests_run++;
        if (dec_soft !== SOFT_W'(idx)) begin
          tests_failed++; $display("FAIL ovf_order[%0d]: got %0d want %0d", idx, dec_soft, idx);
        end
        idx++;
      end
      prev = dec_valid_in;
    end
    tick(); tick();
    tests_run++;
    if (idx != 16) begin tests_failed++; $display("FAIL ovf_drain: got %0d symbols want 16", idx); end
    tests_run++;
    if (gap_err != 0) begin tests_failed++; $display("FAIL ovf_gap: %0d back-to-back strobes, want 0", gap_err); end
    tests_run++;
    if (fill !== 5'd0) begin tests_failed++; $display("FAIL ovf_empty: fill %0d want 0", fill); end
    $display("[TB] fifo_overflow: drained=%0d gap_err=%0d in_ovf=%b", idx, gap_err, in_ovf);
  endtask

  task automatic test_pack_full();
    do_reset();
    for (int i = 0; i < 16; i++) send_bit((i % 2) == 0, STATE_W'(i + 3));
    tests_run++;
    if ({out_valid, out_word, out_count, out_state} !== {1'b1, 16'h5555, 5'd16, 6'd18}) begin
      tests_failed++;
      $display("FAIL pack_full: valid=%b word=%h cnt=%0d st=%0d want 1 5555 16 18",
               out_valid, out_word, out_count, out_state);
    end
    tick(); tick(); tick();
    tests_run++;
    if ({out_valid, out_word, out_count} !== {1'b1, 16'h5555, 5'd16}) begin
      tests_failed++; $display("FAIL pack_hold: valid=%b word=%h cnt=%0d", out_valid, out_word, out_count);
    end
    send_bit(1'b1, 6'd1);
    tests_run++;
    if ({out_ovf, out_word} !== {STATS, 16'h5555}) begin
      tests_failed++; $display("FAIL pack_ovf: ovf=%b word=%h want %b 5555", out_ovf, out_word, STATS);
    end
    out_ack = 1'b1; dec_valid_out = 1'b1; dec_bit = 1'b1; tick();
    out_ack = 1'b0; dec_valid_out = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0; tick();
    tests_run++;
    if ({out_valid, out_word} !== {1'b0, 16'h0000}) begin
      tests_failed++; $display("FAIL pack_ack_drop: valid=%b word=%h want 0 0000", out_valid, out_word);
    end
    $display("[TB] pack_full: out_ovf=%b after_ack valid=%b", out_ovf, out_valid);
  endtask

  task automatic test_flush();
    do_reset();
    send_bit(1'b1, 6'd7); send_bit(1'b1, 6'd8); send_bit(1'b0, 6'd9);
    flush = 1'b1; tick(); flush = 1'b0;
    tests_run++;
    if ({out_valid, out_word, out_count, out_state} !== {1'b1, 16'h0003, 5'd3, 6'd9}) begin
      tests_failed++;
      $display("FAIL flush_word: valid=%b word=%h cnt=%0d st=%0d want 1 0003 3 9",
               out_valid, out_word, out_count, out_state);
    end
    out_ack = 1'b1; tick(); out_ack = 1'b0;
    tests_run++;
    if ({out_valid, out_word} !== {1'b0, 16'h0000}) begin
      tests_failed++; $display("FAIL flush_ack: valid=%b word=%h want 0 0000", out_valid, out_word);
    end
    send_bit(1'b1, 6'd2);
    flush = 1'b1; dec_valid_out = 1'b1; dec_bit = 1'b1; dec_last_state = 6'd5; tick();
    flush = 1'b0; dec_valid_out = 1'b0;
    tests_run++;
    if ({out_valid, out_word, out_count, out_state} !== {1'b1, 16'h0003, 5'd2, 6'd5}) begin
      tests_failed++;
      $display("FAIL flush_with_bit: valid=%b word=%h cnt=%0d st=%0d want 1 0003 2 5",
               out_valid, out_word, out_count, out_state);
    end
    out_ack = 1'b1; tick(); out_ack = 1'b0;
    $display("[TB] flush: word=%h cnt=%0d", out_word, out_count);
  endtask

  task automatic test_full_push_pop();
    logic [SOFT_W-1:0] exp_q[$];
    int got_n = 0;
    do_reset();
    for (int i = 0; i < 16; i++) push_sym(SOFT_W'(100 + i));
    host_soft = 8'd77; host_valid = 1'b1; dec_ready_in = 1'b1; tick();
    host_valid = 1'b0; dec_ready_in = 1'b0;
    tests_run++;
    if ({fill, in_ovf} !== {5'd16, 1'b0}) begin
      tests_failed++; $display("FAIL fullpp_fill: fill=%0d in_ovf=%b want 16 0", fill, in_ovf);
    end
    tests_run++;
    if ({dec_valid_in, dec_soft} !== {1'b1, 8'd100}) begin
      tests_failed++; $display("FAIL fullpp_first: dvi=%b soft=%0d want 1 100", dec_valid_in, dec_soft);
    end
    for (int i = 1; i < 16; i++) exp_q.push_back(SOFT_W'(100 + i));
    exp_q.push_back(8'd77);
    dec_ready_in = 1'b1;
    for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
      tick();
      if (dec_valid_in) begin
        tests_run++;
        if (dec_soft !== exp_q[0]) begin
          tests_failed++; $display("FAIL fullpp_order[%0d]: got %0d want %0d", got_n, dec_soft, exp_q[0]);
        end
        void'(exp_q.pop_front());
        got_n++;
      end
    end
    tests_run++;
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL fullpp_drain: %0d symbols missing", exp_q.size()); end
    $display("[TB] full_push_pop: drained=%0d in_ovf=%b", got_n, in_ovf);
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    do_reset();
    for (int i = 0; i < 5; i++) push_sym(SOFT_W'(40 + i));
    for (int i = 0; i < 7; i++) send_bit(1'b1, 6'h2A);
    tests_run++;
    if (fill !== 5'd5) begin tests_failed++; $display("FAIL rstmid_pre: fill %0d want 5", fill); end
    sys_rst = 1'b1; tick();
    tests_run++;
    if ({dec_valid_in, dec_soft, out_valid, out_word, out_count, out_state,
         in_ovf, out_ovf, sym_count, fill} !== '0) begin
      tests_failed++;
      $display("FAIL rstmid_zero: ov=%b word=%h cnt=%0d st=%0d fill=%0d",
               out_valid, out_word, out_count, out_state, fill);
    end
    sys_rst = 1'b0; tick();
    send_bit(1'b1, 6'd3);
    flush = 1'b1; tick(); flush = 1'b0;
    tests_run++;
    if ({out_valid, out_word, out_count} !== {1'b1, 16'h0001, 5'd1}) begin
      tests_failed++; $display("FAIL rstmid_word: valid=%b word=%h cnt=%0d want 1 0001 1", out_valid, out_word, out_count);
    end
    out_ack = 1'b1; tick(); out_ack = 1'b0;
    push_sym(8'h33);
    dec_ready_in = 1'b1;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      tick();
      if (dec_valid_in) begin
        seen = 1;
        tests_run++;
        if ({dec_soft, sym_count} !== {8'h33, (STATS ? 32'd1 : 32'd0)}) begin
          tests_failed++; $display("FAIL rstmid_sym: soft=%h count=%0d want 33 %0d", dec_soft, sym_count, STATS ? 1 : 0);
        end
      end
    end
    tests_run++;
    if (seen == 0) begin tests_failed++; $display("FAIL rstmid_timeout: no strobe within 20 cycles"); end
    $display("[TB] reset_mid: post-reset word=%h", out_word);
  endtask

  task automatic test_random();
    logic [SOFT_W-1:0] model_q[$];
    int n;
    int gap_err = 0;
    logic prev = 1'b0;
    do_reset();
    n = $urandom_range(4, 16);
    for (int i = 0; i < n; i++) begin
      logic [SOFT_W-1:0] v;
      v = SOFT_W'($urandom);
      model_q.push_back(v);
      push_sym(v);
    end
    tests_run++;
    if (fill !== 5'(n)) begin tests_failed++; $display("FAIL rand_fill: got %0d want %0d", fill, n); end
    for (int c = 0; c < 400 && model_q.size() > 0; c++) begin
      dec_ready_in = 1'($urandom_range(0, 1));
      tick();
      if (dec_valid_in) begin
        if (prev) gap_err++;
        tests_run++;
        if (dec_soft !== model_q[0]) begin
          tests_failed++; $display("FAIL rand_sym: got %h want %h", dec_soft, model_q[0]);
        end
        void'(model_q.pop_front());
      end
      prev = dec_valid_in;
    end
    dec_ready_in = 1'b0;
    tests_run++;
    if (model_q.size() != 0 || gap_err != 0) begin
      tests_failed++; $display("FAIL rand_drain: left=%0d gap_err=%0d want 0 0", model_q.size(), gap_err);
    end
    $display("[TB] random_symbols: n=%0d", n);
    for (int r = 0; r < 6; r++) begin
      int k;
      logic [OUT_W-1:0]   exp_word;
      logic [STATE_W-1:0] exp_st;
      k = $urandom_range(1, 16);
      exp_word = '0;
      exp_st = '0;
      for (int j = 0; j < k; j++) begin
        logic b;
        logic [STATE_W-1:0] st;
        b = 1'($urandom);
        st = STATE_W'($urandom);
        exp_word[j] = b;
        exp_st = st;
        send_bit(b, st);
        if ($urandom_range(0, 2) == 0) tick();
      end
      if (k < 16) begin flush = 1'b1; tick(); flush = 1'b0; end
      tests_run++;
      if ({out_valid, out_word, out_count, out_state} !== {1'b1, exp_word, 5'(k), exp_st}) begin
        tests_failed++;
        $display("FAIL rand_word[%0d]: valid=%b word=%h cnt=%0d st=%0d want 1 %h %0d %0d",
                 r, out_valid, out_word, out_count, out_state, exp_word, k, exp_st);
      end
      $display("[TB] random_word %0d: k=%0d word=%h", r, k, out_word);
      out_ack = 1'b1; tick(); out_ack = 1'b0; tick();
    end
  endtask

  initial begin
    test_reset();
    test_edge_level();
    test_fifo_overflow();
    test_pack_full();
    test_flush();
    test_full_push_pop();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vit_stream_adapter.md
VIT_STREAM_ADAPTER -- requirements
Module: vit_stream_adapter

Interface
REQ-001 SHALL have parameter SOFT_W, default 8: signed soft-symbol width.
REQ-002 SHALL have parameter DEPTH, default 16: input FIFO depth, power of two, 4 to 256.
REQ-003 SHALL have parameter OUT_W, default 16: decoded bits per packed output word, 2 to 64.
REQ-004 SHALL have parameter STATE_W, default 6: decoder state width.
REQ-005 SHALL have parameter EDGE_MODE, default 1: 1 means host_valid is a level and only its rising edge pushes; 0 means every high cycle pushes.
REQ-006 SHALL have ports, in this order:
- clk  in  1  sole clock.
- sys_rst  in  1  synchronous, active-high reset.
- host_valid  in  1  symbol write strobe or level.
- host_soft  in  SOFT_W  soft symbol.
- flush  in  1  pulse; emit the partial word.
- dec_ready_in  in  1  decoder can accept a symbol.
- dec_soft  out  SOFT_W  symbol to the decoder.
- dec_valid_in  out  1  one-cycle symbol strobe.
- dec_valid_out  in  1  decoder bit strobe.
- dec_bit  in  1  decoded bit.
- dec_last_state  in  STATE_W  decoder final state.
- out_valid  out  1  packed word available.
- out_word  out  OUT_W  packed bits, first bit in LSB.
- out_count  out  clog2(OUT_W+1)  number of valid bits in out_word.
- out_state  out  STATE_W  dec_last_state captured with the last bit of the word.
- out_ack  in  1  consumer takes the word.
- in_ovf  out  1  sticky: an input symbol was dropped.
- out_ovf  out  1  sticky: a decoded bit was dropped.
- sym_count  out  32  symbols handed to the decoder.
- fill  out  clog2(DEPTH+1)  input FIFO occupancy.

Function
REQ-007 SHALL, when EDGE_MODE=1, push a symbol in the cycle after host_valid rises (registered previous value); a level held high SHALL push exactly once.
REQ-008 SHALL drop a push when the FIFO is full and no pop occurs in the same cycle, and SHALL set in_ovf.
REQ-009 SHALL accept a push into a full FIFO when a pop happens in the same cycle; fill stays unchanged.
REQ-010 SHALL pop when the FIFO is not empty and dec_ready_in=1; the next cycle dec_valid_in=1 for exactly one cycle, with dec_soft holding the popped value.
REQ-011 SHALL keep at least one idle cycle between dec_valid_in pulses; issue rate is at most one symbol per 2 cycles.
REQ-012 SHALL never pop while empty; dec_valid_in stays 0.
REQ-013 SHALL wrap the FIFO pointers modulo DEPTH; occupancy SHALL be tracked with an explicit count, not by pointer comparison.
REQ-014 SHALL run the output FSM with states PACK and HOLD; both out_valid=0 and the bit index=0 in PACK.
REQ-015 SHALL, in PACK, on dec_valid_out, write dec_bit to bit position idx and increment idx; when idx reaches OUT_W-1 it SHALL capture dec_last_state into out_state, set out_count=OUT_W and go to HOLD.
REQ-016 SHALL, in PACK, on flush with idx>0, set out_count=idx and go to HOLD; flush with idx=0 SHALL be ignored.
REQ-017 SHALL, on a simultaneous flush and dec_valid_out, pack the bit first and then flush it as part of the word.
REQ-018 SHALL, in HOLD, assert out_valid with out_word, out_count and out_state stable until out_ack; on out_ack it SHALL clear out_word and return to PACK.
REQ-019 SHALL, in HOLD, drop any dec_valid_out, including one in the out_ack cycle, and set out_ovf.
REQ-020 SHALL increment sym_count on each dec_valid_in and wrap at 2^32.

Reset
REQ-021 SHALL, while sys_rst is high, clear the FIFO, fill, idx, dec_valid_in, dec_soft, out_valid, out_word, out_count, out_state, in_ovf, out_ovf, sym_count and the host_valid history; the FSM SHALL go to PACK.
REQ-022 SHALL, when reset is asserted mid-operation, discard in-flight symbols and the partial word; the first push after reset SHALL behave as from power-up.

Configuration
REQ-023 SHALL, with VIT_STREAM_ADAPTER_STATS_EN defined, implement sym_count, in_ovf and out_ovf as specified.
REQ-024 SHALL, without that macro, tie sym_count, in_ovf and out_ovf to 0 with the port list unchanged; the dropping behaviour SHALL be unchanged.

Structure
REQ-025 SHALL define the FSM state enum (PACK, HOLD) and the width defaults in package vit_stream_pkg.
REQ-026 SHALL implement the input FIFO as sub-module vit_sym_fifo (push, pop, full, empty, count), with one-cycle registered read data.

Verification
REQ-027 SHALL cover: EDGE_MODE=1, host_valid held high for 10 cycles with value -5 -> exactly one dec_valid_in, with dec_soft=-5 and sym_count=1.
REQ-028 SHALL cover: dec_ready_in=0, 20 pushes with DEPTH=16 -> fill=16, in_ovf=1; after ready, values 0..15 are issued in order.
REQ-029 SHALL cover: 16 bits 1,0,1,0,... with out_ack=0 -> out_word=16'h5555, out_count=16, out_valid held; a 17th bit -> out_ovf=1.
REQ-030 SHALL cover: 3 bits 1,1,0 then flush -> out_word=16'h0003, out_count=3; out_ack -> PACK with out_valid=0.
REQ-031 SHALL cover: full FIFO with push and pop in the same cycle -> fill stays 16 and in_ovf is not set.
REQ-032 SHALL cover: sys_rst asserted with 7 bits packed and fill=5 -> all outputs zero the next cycle, and the subsequent word starts at bit 0.
